// File: rtl/alu_sliced_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_sliced_seq : multi-cycle ALU, one SLICE-bit slice per clock          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_sliced_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             set,
  output logic             overflow,
  output logic             cout
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] c_last = KW'(N - 1);

  localparam logic [2:0] c_op_and = 3'b000;
  localparam logic [2:0] c_op_or  = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_xor = 3'b011;
  localparam logic [2:0] c_op_nor = 3'b100;
  localparam logic [2:0] c_op_sub = 3'b110;
  localparam logic [2:0] c_op_slt = 3'b111;

  generate
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_param_check
      $error("alu_sliced_seq: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [2:0]        r_op;
  logic [KW-1:0]     r_k;
  logic              r_carry;

  logic [31:0]       w_base;
  logic [SLICE-1:0]  w_a_sl;
  logic [SLICE-1:0]  w_bx_sl;
  logic [SLICE-1:0]  w_sum_sl;
  logic [SLICE-1:0]  w_logic_sl;
  logic [SLICE-1:0]  w_slice;
  logic              w_c_out;
  logic              w_c_msb;
  logic              w_ov;
  logic              w_set;
  logic              w_arith;
  logic              w_addsub;
  logic              w_last;
  logic [WIDTH-1:0]  w_res_next;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  assign w_base  = 32'(r_k) * 32'(SLICE);
  assign w_a_sl  = r_a[w_base +: SLICE];
  assign w_bx_sl = r_op[2] ? ~r_b[w_base +: SLICE] : r_b[w_base +: SLICE];
  assign {w_c_out, w_sum_sl} = {1'b0, w_a_sl} + {1'b0, w_bx_sl} + {{SLICE{1'b0}}, r_carry};

  // Carry into the slice MSB recovered from the sum bit, so no second adder is needed.
  assign w_c_msb  = w_sum_sl[SLICE-1] ^ w_a_sl[SLICE-1] ^ w_bx_sl[SLICE-1];
  assign w_ov     = w_c_msb ^ w_c_out;
  assign w_set    = w_sum_sl[SLICE-1] ^ w_ov;
  assign w_addsub = (r_op == c_op_add) || (r_op == c_op_sub);
  assign w_arith  = w_addsub || (r_op == c_op_slt);
  assign w_last   = (r_k == c_last);
  assign w_slice  = w_arith ? w_sum_sl : w_logic_sl;

  always_comb begin
    w_logic_sl = '0;
    case (r_op)
      c_op_and: w_logic_sl = r_a[w_base +: SLICE] & r_b[w_base +: SLICE];
      c_op_or:  w_logic_sl = r_a[w_base +: SLICE] | r_b[w_base +: SLICE];
      c_op_xor: w_logic_sl = r_a[w_base +: SLICE] ^ r_b[w_base +: SLICE];
      c_op_nor: w_logic_sl = ~(r_a[w_base +: SLICE] | r_b[w_base +: SLICE]);
      default:  w_logic_sl = '0;
    endcase
  end

  always_comb begin
    w_res_next = result;
    w_res_next[w_base +: SLICE] = w_slice;
    if (w_last && (r_op == c_op_slt)) begin
      w_res_next = WIDTH'(w_set);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
      S_BUSY:  if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_k      <= '0;
      r_carry  <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      set      <= 1'b0;
      overflow <= 1'b0;
      cout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_k     <= '0;
            r_carry <= op[2];
          end
        end
        S_BUSY: begin
          result  <= w_res_next;
          r_carry <= w_c_out;
          r_k     <= r_k + KW'(1);
          if (w_last) begin
            zero     <= (w_res_next == '0);
            overflow <= w_addsub & w_ov;
            cout     <= w_addsub & w_c_out;
            set      <= (r_op == c_op_slt) & w_set;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
